booth_pp_accum: RTL and testbench
=================================

// Module: booth_pp_accum
// PURPOSE
//  Consumer end of the radix-4 Booth partial-product stream. Accepts one signed
//  LENGTH+2-bit partial product per handshake, least-significant Booth digit first.
//  Weights each product by 4^idx and accumulates the result.
//  Once NPP products have arrived, presents the 2*LENGTH-bit product on a
//  valid/ready output. Sits between the Booth encoder stage and the product consumer.
// PARAMETERS
//  LENGTH  32  operand width; must be even and >= 4
//  NPP     (derived localparam) LENGTH/2 signed; LENGTH/2+1 when `UNSINGED_BOOTH defined
//  IDX_W   (derived localparam) $clog2(NPP+1), width of digit counter
// PORTS
//  clk_i         in   1           clock, rising edge
//  rst_n_i       in   1           asynchronous reset, active low
//  clr_i         in   1           synchronous abort; discards all in-flight state
//  pp_i          in   LENGTH+2    two's-complement partial product for digit idx
//  pp_valid_i    in   1           pp_i valid
//  pp_ready_o    out  1           block can accept pp_i
//  prod_o        out  2*LENGTH    accumulated product, mod 2^(2*LENGTH)
//  prod_valid_o  out  1           prod_o valid
//  prod_ready_i  in   1           downstream accepts prod_o
//  busy_o        out  1           1 while 0 < idx (partial accumulation pending)
// BEHAVIOUR
//  - Asynchronous reset:
//      state = S_ACC, acc = 0, idx = 0, prod_o = 0, prod_valid_o = 0, busy_o = 0.
//      pp_ready_o = 1, since it is decoded from state.
//  - FSM has two states:
//      S_ACC: pp_ready_o = 1, prod_valid_o = 0.
//      S_OUT: pp_ready_o = 0, prod_valid_o = 1.
//  - Accept condition is pp_valid_i & pp_ready_o. On accept:
//      term = sext(pp_i to 2*LENGTH) << (2*idx), truncated to 2*LENGTH bits.
//      If idx < NPP-1: acc <= acc + term; idx <= idx + 1.
//      If idx == NPP-1: prod_o <= acc + term; prod_valid_o <= 1; acc <= 0;
//        idx <= 0; go to S_OUT.
//  - Latency: prod_valid_o rises on the cycle after the last pp is accepted.
//  - Throughput is NPP+1 cycles per product (one bubble in S_OUT).
//  - S_OUT holds prod_o and prod_valid_o stable until prod_ready_i = 1.
//  - On the output handshake: prod_valid_o <= 0, return to S_ACC.
//  - There is no output-to-input bypass: pp_valid_i is ignored in S_OUT.
//  - Arithmetic wraps mod 2^(2*LENGTH); no overflow flag.
//      Signed mode: exact signed product.
//      Unsigned mode: exact unsigned product.
//  - clr_i has highest priority over any handshake in the same cycle:
//      acc, idx <= 0; prod_valid_o <= 0; state <= S_ACC.
//      prod_o keeps its old value and is not valid.
//  - Reset asserted mid-operation: asynchronous clear of all state.
//      The partial sum is lost and no product is emitted.
//  - pp_valid_i may drop between products; idx is held while idle.
// STRUCTURE
//  - Shared include: mode macro UNSINGED_BOOTH in UnsignedChoose.v.
//    NPP and IDX_W are computed from it as localparams inside the module.
//  - Sub-module booth_pp_shift: combinational. Sign-extends pp_i and shifts by
//    2*idx to produce term. Instantiated once.
//  - Top level holds the FSM, idx counter, acc adder and output register.
// TESTING  (LENGTH=8, signed unless noted)
//  1. Send pp = 0x3FD, 0x3FD, 0x000, 0x000 (a=-3, b=5)
//     -> prod_o = 0xFFF1, prod_valid_o exactly 1 cycle after 4th accept.
//  2. Send pp = 0, 0, 0, 0x100 (a=-128, b=-128) -> prod_o = 0x4000.
//  3. Hold prod_ready_i = 0 for 3 cycles after product, pp_valid_i = 1
//     -> prod_o stable, pp_ready_o = 0, no pp consumed; next product is correct.
//  4. pp_valid_i and prod_ready_i tied high, 3 products
//     -> a product every 5 cycles with correct values.
//  5. Accept 2 pps, pulse clr_i, then send test-1 stream
//     -> prod_o = 0xFFF1, no spurious prod_valid_o.
//  6. Assert rst_n_i low after 3 accepts -> all outputs at reset values immediately.
//     Then the test-2 stream -> 0x4000.
//     With `UNSINGED_BOOTH defined, 5 pps for 255*255 -> prod_o = 0xFE01.

Source files
------------

// File: rtl/booth_pp_accum_pkg.sv
// Shared types and helpers for the radix-4 Booth partial-product accumulator.
package booth_pp_accum_pkg;

    // Accumulator FSM: collecting partial products, or presenting a product.
    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } acc_state_e;

    // Number of Booth digits for an operand of the given width. Unsigned
    // operands need one extra digit to absorb the implicit zero sign bit.
    function automatic int booth_npp(input int length, input bit unsigned_mode);
        int npp;
        npp = length / 2;
        if (unsigned_mode) begin
            npp = npp + 1;
        end else begin
            npp = npp + 0;
        end
        return npp;
    endfunction

endpackage

// File: rtl/booth_pp_accum_shift.sv
// Combinational weighting of one Booth partial product: sign-extend the
// LENGTH+2-bit two's-complement product to 2*LENGTH bits and scale by 4^idx.
module booth_pp_shift #(
    parameter int LENGTH = 32,
    parameter int IDX_W  = 5
) (
    input  logic [LENGTH+1:0]   pp_i,
    input  logic [IDX_W-1:0]    idx_i,
    output logic [2*LENGTH-1:0] term_o
);

    logic [2*LENGTH-1:0] pp_sext_s;
    logic [IDX_W:0]      shamt_s;

    // Sign-extend, then shift left by two bits per digit position (bits shifted
    // past 2*LENGTH are dropped, giving the mod 2^(2*LENGTH) wrap).
    always_comb begin
        pp_sext_s = {{(LENGTH-2){pp_i[LENGTH+1]}}, pp_i};
        shamt_s   = {idx_i, 1'b0};
        term_o    = pp_sext_s << shamt_s;
    end

endmodule

// File: rtl/booth_pp_accum.sv
// Consumer end of the radix-4 Booth partial-product stream. Accumulates NPP
// weighted partial products (least-significant digit first) and presents the
// 2*LENGTH-bit product on a valid/ready output.
// The operand mode comes from the UNSINGED_BOOTH macro supplied by the shared
// build include; when defined an extra Booth digit is expected.
module booth_pp_accum
    import booth_pp_accum_pkg::*;
#(
    parameter int LENGTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                clr_i,
    input  logic [LENGTH+1:0]   pp_i,
    input  logic                pp_valid_i,
    output logic                pp_ready_o,
    output logic [2*LENGTH-1:0] prod_o,
    output logic                prod_valid_o,
    input  logic                prod_ready_i,
    output logic                busy_o
);

`ifdef UNSINGED_BOOTH
    localparam bit UNS_MODE = 1'b1;
`else
    localparam bit UNS_MODE = 1'b0;
`endif
    localparam int NPP   = booth_npp(LENGTH, UNS_MODE);
    localparam int IDX_W = $clog2(NPP + 1);
    localparam int PW    = 2 * LENGTH;

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPP - 1);
    localparam logic [PW-1:0]    ACC_ZERO = {PW{1'b0}};

    acc_state_e        state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic              prod_valid_q, prod_valid_d;
    logic              busy_q, busy_d;

    logic [PW-1:0]     term_s;
    logic [PW-1:0]     sum_s;

    booth_pp_shift #(
        .LENGTH (LENGTH),
        .IDX_W  (IDX_W)
    ) u_shift (
        .pp_i   (pp_i),
        .idx_i  (idx_q),
        .term_o (term_s)
    );

    // Next-state logic: clear beats any handshake; otherwise accumulate in
    // S_ACC and hold the product in S_OUT until the consumer takes it.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        prod_d       = prod_q;
        prod_valid_d = prod_valid_q;
        sum_s        = acc_q + term_s;

        if (clr_i) begin
            state_d      = S_ACC;
            acc_d        = ACC_ZERO;
            idx_d        = IDX_ZERO;
            prod_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (pp_valid_i) begin
                        if (idx_q == IDX_LAST) begin
                            prod_d       = sum_s;
                            prod_valid_d = 1'b1;
                            acc_d        = ACC_ZERO;
                            idx_d        = IDX_ZERO;
                            state_d      = S_OUT;
                        end else begin
                            acc_d = sum_s;
                            idx_d = idx_q + IDX_ONE;
                        end
                    end else begin
                        state_d = S_ACC;
                    end
                end
                S_OUT: begin
                    if (prod_ready_i) begin
                        prod_valid_d = 1'b0;
                        state_d      = S_ACC;
                    end else begin
                        state_d = S_OUT;
                    end
                end
                default: begin
                    state_d      = S_ACC;
                    acc_d        = ACC_ZERO;
                    idx_d        = IDX_ZERO;
                    prod_valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (idx_d != IDX_ZERO);
    end

    // State, accumulator, digit counter and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_ACC;
            acc_q        <= ACC_ZERO;
            idx_q        <= IDX_ZERO;
            prod_q       <= ACC_ZERO;
            prod_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign pp_ready_o   = (state_q == S_ACC);
    assign prod_o       = prod_q;
    assign prod_valid_o = prod_valid_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_booth_pp_accum.sv
// Self-checking bench for booth_pp_accum (LENGTH = 8). Expected products come
// from integer multiplication of the operands; partial products are derived
// from the radix-4 Booth digit rule applied to the multiplier.
module tb_booth_pp_accum;

    localparam int LENGTH = 8;
    localparam int PPW    = LENGTH + 2;
    localparam int PW     = 2 * LENGTH;
`ifdef UNSINGED_BOOTH
    localparam int NPP = LENGTH / 2 + 1;
`else
    localparam int NPP = LENGTH / 2;
`endif

    logic           clk;
    logic           rst_n_i;
    logic           clr_i;
    logic [PPW-1:0] pp_i;
    logic           pp_valid_i;
    logic           pp_ready_o;
    logic [PW-1:0]  prod_o;
    logic           prod_valid_o;
    logic           prod_ready_i;
    logic           busy_o;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [PPW-1:0] pp_q[$];
    logic [PW-1:0]  exp_v;

    booth_pp_accum #(.LENGTH(LENGTH)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .clr_i        (clr_i),
        .pp_i         (pp_i),
        .pp_valid_i   (pp_valid_i),
        .pp_ready_o   (pp_ready_o),
        .prod_o       (prod_o),
        .prod_valid_o (prod_valid_o),
        .prod_ready_i (prod_ready_i),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Booth partial products of a*b into pp_q, expected product into exp_v.
    task automatic make_pps(input int a, input int b);
        int hi, mid, lo, digit, p;
        pp_q.delete();
        for (int i = 0; i < NPP; i++) begin
            hi    = (b >>> (2 * i + 1)) & 1;
            mid   = (b >>> (2 * i)) & 1;
            lo    = (i == 0) ? 0 : ((b >>> (2 * i - 1)) & 1);
            digit = -2 * hi + mid + lo;
            p     = a * digit;
            pp_q.push_back(PPW'(p));
        end
        exp_v = PW'(a * b);
    endtask

    // Present one pp (after an optional idle gap) and return at the falling
    // edge after it has been accepted.
    task automatic send_pp(input logic [PPW-1:0] v, input int gap);
        int n;
        for (int g = 0; g < gap; g++) @(negedge clk);
        pp_i = v;
        pp_valid_i = 1'b1;
        n = 0;
        while (pp_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL send_pp_timeout: pp_ready_o=%b required 1", pp_ready_o);
        end
        @(posedge clk);
        @(negedge clk);
        pp_valid_i = 1'b0;
    endtask

    // Take the presented product with a one-cycle ready pulse.
    task automatic pop_prod();
        prod_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        prod_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; clr_i = 1'b0; pp_i = '0; pp_valid_i = 1'b0; prod_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        cmp_cnt++; if (prod_o !== 16'h0000) begin err_cnt++; $display("FAIL reset_prod: got %h required 0000", prod_o); end
        cmp_cnt++; if (prod_valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b required 0", prod_valid_o); end
        cmp_cnt++; if (pp_ready_o !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b required 1", pp_ready_o); end
        cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b required 0", busy_o); end
        rst_n_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pp_q = '{10'h3FD, 10'h3FD, 10'h000, 10'h000};
        for (int i = 0; i < 3; i++) send_pp(pp_q[i], 0);
        cmp_cnt++; if (prod_valid_o !== 1'b0) begin err_cnt++; $display("FAIL t1_early_valid: got %b required 0", prod_valid_o); end
        cmp_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL t1_busy: got %b required 1", busy_o); end
        send_pp(pp_q[3], 0);
        cmp_cnt++; if (prod_valid_o !== 1'b1 || prod_o !== 16'hFFF1) begin err_cnt++; $display("FAIL t1_prod: got v=%b %h required v=1 fff1", prod_valid_o, prod_o); end
        cmp_cnt++; if (pp_ready_o !== 1'b0 || busy_o !== 1'b0) begin err_cnt++; $display("FAIL t1_out_state: got ready=%b busy=%b required 0 0", pp_ready_o, busy_o); end
        pop_prod();
        cmp_cnt++; if (prod_valid_o !== 1'b0 || pp_ready_o !== 1'b1) begin err_cnt++; $display("FAIL t1_after_pop: got v=%b ready=%b required 0 1", prod_valid_o, pp_ready_o); end

        pp_q = '{10'h000, 10'h000, 10'h000, 10'h100};
        for (int i = 0; i < 4; i++) send_pp(pp_q[i], i % 2);
        cmp_cnt++; if (prod_valid_o !== 1'b1 || prod_o !== 16'h4000) begin err_cnt++; $display("FAIL t2_prod: got v=%b %h required v=1 4000", prod_valid_o, prod_o); end
        pop_prod();
    endtask

    task automatic test_backpressure();
        pp_q = '{10'h3FD, 10'h3FD, 10'h000, 10'h000};
        for (int i = 0; i < 4; i++) send_pp(pp_q[i], 0);
        pp_i = 10'h001;
        pp_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            cmp_cnt++;
            if (prod_o !== 16'hFFF1 || prod_valid_o !== 1'b1 || pp_ready_o !== 1'b0 || busy_o !== 1'b0) begin
                err_cnt++;
                $display("FAIL t3_hold[%0d]: got %h v=%b ready=%b busy=%b required fff1 1 0 0", c, prod_o, prod_valid_o, pp_ready_o, busy_o);
            end
        end
        pp_valid_i = 1'b0;
        pop_prod();
        pp_q = '{10'h000, 10'h000, 10'h000, 10'h100};
        for (int i = 0; i < 4; i++) send_pp(pp_q[i], 0);
        cmp_cnt++; if (prod_valid_o !== 1'b1 || prod_o !== 16'h4000) begin err_cnt++; $display("FAIL t3_next_prod: got v=%b %h required v=1 4000", prod_valid_o, prod_o); end
        pop_prod();
    endtask

    task automatic test_back_to_back();
        logic [PPW-1:0] all_q[$];
        logic [PW-1:0]  exp_q[$];
        int k, got, last_cyc;
        bit acc;
        for (int p = 0; p < 3; p++) begin
`ifdef UNSINGED_BOOTH
            make_pps(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
`else
            make_pps(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
`endif
            foreach (pp_q[i]) all_q.push_back(pp_q[i]);
            exp_q.push_back(exp_v);
        end
        prod_ready_i = 1'b1;
        k = 0; got = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            if (prod_valid_o === 1'b1) begin
                cmp_cnt++;
                if (prod_o !== exp_q[got]) begin err_cnt++; $display("FAIL t4_prod[%0d]: got %h required %h", got, prod_o, exp_q[got]); end
                if (got > 0) begin
                    cmp_cnt++;
                    if (cyc - last_cyc != NPP + 1) begin err_cnt++; $display("FAIL t4_period[%0d]: got %0d required %0d", got, cyc - last_cyc, NPP + 1); end
                end
                last_cyc = cyc;
                got++;
            end
            pp_valid_i = (k < 3 * NPP);
            pp_i = (k < 3 * NPP) ? all_q[k] : '0;
            acc = pp_valid_i && pp_ready_o;
            @(posedge clk);
            if (acc) k++;
            @(negedge clk);
        end
        pp_valid_i = 1'b0;
        cmp_cnt++; if (got != 3) begin err_cnt++; $display("FAIL t4_count: got %0d products required 3", got); end
        @(posedge clk);
        @(negedge clk);
        prod_ready_i = 1'b0;
    endtask

    task automatic test_clear();
        pp_q = '{10'h3FD, 10'h3FD, 10'h000, 10'h000};
        send_pp(pp_q[0], 0);
        send_pp(pp_q[1], 0);
        clr_i = 1'b1; pp_valid_i = 1'b1; pp_i = 10'h3FD;
        @(posedge clk);
        @(negedge clk);
        clr_i = 1'b0; pp_valid_i = 1'b0;
        cmp_cnt++; if (busy_o !== 1'b0 || pp_ready_o !== 1'b1 || prod_valid_o !== 1'b0) begin err_cnt++; $display("FAIL t5_after_clr: got busy=%b ready=%b v=%b required 0 1 0", busy_o, pp_ready_o, prod_valid_o); end
        for (int i = 0; i < 3; i++) send_pp(pp_q[i], 0);
        cmp_cnt++; if (prod_valid_o !== 1'b0) begin err_cnt++; $display("FAIL t5_spurious_valid: got %b required 0", prod_valid_o); end
        send_pp(pp_q[3], 0);
        cmp_cnt++; if (prod_valid_o !== 1'b1 || prod_o !== 16'hFFF1) begin err_cnt++; $display("FAIL t5_prod: got v=%b %h required v=1 fff1", prod_valid_o, prod_o); end
        clr_i = 1'b1; prod_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_i = 1'b0; prod_ready_i = 1'b0;
        cmp_cnt++; if (prod_valid_o !== 1'b0 || prod_o !== 16'hFFF1 || pp_ready_o !== 1'b1) begin err_cnt++; $display("FAIL t5_clr_out: got v=%b %h ready=%b required 0 fff1 1", prod_valid_o, prod_o, pp_ready_o); end
    endtask

    task automatic test_async_reset();
        pp_q = '{10'h3FD, 10'h3FD, 10'h000, 10'h000};
        for (int i = 0; i < 3; i++) send_pp(pp_q[i], 0);
        cmp_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL t6_busy: got %b required 1", busy_o); end
        #2 rst_n_i = 1'b0;
        #1;
        cmp_cnt++;
        if (prod_o !== 16'h0000 || prod_valid_o !== 1'b0 || busy_o !== 1'b0 || pp_ready_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL t6_reset_now: got %h v=%b busy=%b ready=%b required 0000 0 0 1", prod_o, prod_valid_o, busy_o, pp_ready_o);
        end
        @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);
        pp_q = '{10'h000, 10'h000, 10'h000, 10'h100};
        for (int i = 0; i < 4; i++) send_pp(pp_q[i], 0);
        cmp_cnt++; if (prod_valid_o !== 1'b1 || prod_o !== 16'h4000) begin err_cnt++; $display("FAIL t6_prod: got v=%b %h required v=1 4000", prod_valid_o, prod_o); end
        pop_prod();
    endtask

    task automatic test_unsigned();
        make_pps(255, 255);
        for (int i = 0; i < NPP; i++) send_pp(pp_q[i], 0);
        cmp_cnt++; if (prod_valid_o !== 1'b1 || prod_o !== 16'hFE01) begin err_cnt++; $display("FAIL unsigned_prod: got v=%b %h required v=1 fe01", prod_valid_o, prod_o); end
        pop_prod();
    endtask

    task automatic test_random();
        int a, b, d;
        for (int t = 0; t < 20; t++) begin
`ifdef UNSINGED_BOOTH
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
`else
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
`endif
            make_pps(a, b);
            for (int i = 0; i < NPP; i++) send_pp(pp_q[i], int'($urandom_range(0, 2)));
            d = int'($urandom_range(0, 3));
            for (int c = 0; c < d; c++) begin
                @(posedge clk);
                @(negedge clk);
            end
            cmp_cnt++;
            if (prod_valid_o !== 1'b1 || prod_o !== exp_v) begin
                err_cnt++;
                $display("FAIL rand_prod[%0d] a=%0d b=%0d: got v=%b %h required v=1 %h", t, a, b, prod_valid_o, prod_o, exp_v);
            end
            pop_prod();
        end
    endtask

    initial begin
        test_reset();
`ifdef UNSINGED_BOOTH
        test_unsigned();
`else
        test_basic();
        test_backpressure();
        test_clear();
        test_async_reset();
`endif
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
